dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder at the far end of the EX/MEM pipeline interface.
- Consumes the registered load/store request (address, store data, read/write controls) and services it against a multi-cycle word memory.
- Holds the pipeline with stall_o until the access completes.
- Returns load data toward MEM/WB.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, at least 4.
- LATENCY, 2, wait cycles before the access commits; at least 1.
- AW, clog2(DEPTH), localparam word-index width; not overridable.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- mem_read_i  input  1  load request from the EX/MEM register (MemToReg).
- mem_write_i  input  1  store request from the EX/MEM register (MemWrite).
- addr_i  input  32  byte address (ALUResult).
- wdata_i  input  32  store data (RDData).
- stall_o  output  1  freeze PC, IF/ID, ID/EX and EX/MEM while high.
- done_o  output  1  one-cycle pulse when the access completes.
- rdata_o  output  32  load data; holds the last load result.

Behaviour:
- Reset: one clock; asynchronous active-low reset on rst_n_i.
  - All state registers clear: state=IDLE, counter=0, latched request=0, rdata_o=0, done_o=0.
  - stall_o=0 while reset is asserted.
  - The memory array is not reset.
- Request: req = mem_read_i | mem_write_i. If both are high, the access is a store; the load is ignored and rdata_o is unchanged.
- Word index: addr_i[AW+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH words.
- FSM states:
  - IDLE: stall_o = req (combinational). On req, latch the index, wdata and write flag; counter <= LATENCY-1; go to WAIT. With no req, stay in IDLE.
  - WAIT: stall_o=1. If counter != 0, decrement. If counter == 0, commit the access and go to RESP.
    - Store: array[index] <= latched wdata.
    - Load: rdata_o <= array[index].
  - RESP: stall_o=0, done_o=1. The request on the inputs counts as consumed. Go to IDLE unconditionally.
- Handshake rules:
  - A request stalls for LATENCY+1 cycles: 1 in IDLE plus LATENCY in WAIT. stall_o is low in RESP.
  - EX/MEM advances on the RESP-cycle edge, so the next request is first seen in IDLE. Back-to-back requests therefore cost LATENCY+2 cycles each.
  - Inputs are sampled only in IDLE. Changes during WAIT/RESP have no effect.
- Simultaneous events:
  - rdata_o changes only at a load commit.
  - done_o is registered: high exactly in the RESP cycle.
- Reset mid-operation: abort to IDLE, no write committed, rdata_o=0.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign_o (1 bit, reset 0).
  - In IDLE, a req with addr_i[1:0] != 0 skips WAIT and goes straight to RESP. No array access; rdata_o is unchanged.
  - misalign_o=1 and done_o=1 in that RESP cycle. The stall lasts 1 cycle.
- Undefined: addr_i[1:0] is ignored; no misalign_o port.

Decomposition:
- Package dmem_pkg:
  - state enum {IDLE, WAIT, RESP}, 2 bits.
  - WORD_W=32.
  - BYTE_OFF_W=2.
- Sub-module dmem_array:
  - single-port synchronous RAM, DEPTH x 32.
  - ports: we, index, wdata, rdata.
  - The responder enables it only at commit.

Test Plan:
- LATENCY=2. Store 0xDEADBEEF to 0x10, then load 0x10:
  - stall_o high 3 cycles for each request, done_o pulses once per request.
  - rdata_o=0xDEADBEEF after the load's RESP cycle.
- Both mem_read_i and mem_write_i high, addr 0x20, wdata 0x12345678:
  - treated as a store; rdata_o unchanged.
  - a later load of 0x20 returns 0x12345678.
- DEPTH=256. Store 0xA5A5A5A5 to 0x400 (index wraps to 0), then load 0x0:
  - returns 0xA5A5A5A5.
- Assert rst_n_i low in WAIT of a store of 0x1 to 0x8:
  - stall_o=0 immediately, state IDLE.
  - a later load of 0x8 returns the prior contents.
- Hold req low for 5 cycles:
  - stall_o=0, done_o=0, rdata_o stable throughout.
- DMEM_MISALIGN_TRAP_EN defined. Load from 0x13:
  - stall_o high 1 cycle, then misalign_o=1 and done_o=1 for 1 cycle.
  - rdata_o unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BYTE_OFF_W = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous write, read of the addressed word.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     index_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[index_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[index_i];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder that stalls the pipeline until a load/store commits.
// Optional misaligned-access trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [31:0]       addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [WORD_W-1:0] rdata_o
`ifdef DMEM_MISALIGN_TRAP_EN
  ,
  output logic              misalign_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  dmem_state_e       state_q;
  logic [CW-1:0]     cnt_q;
  logic [AW-1:0]     idx_q;
  logic [WORD_W-1:0] wdata_q;
  logic              we_q;
  logic [WORD_W-1:0] rdata_q;
  logic              done_q;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic              misalign_q;
`endif

  logic              req;
  logic [AW-1:0]     index;
  logic              commit;
  logic              array_we;
  logic [WORD_W-1:0] array_rdata;
  logic              unused_addr;

  assign req         = mem_read_i | mem_write_i;
  assign index       = addr_i[AW+BYTE_OFF_W-1:BYTE_OFF_W];
  assign commit      = (state_q == StWait) && (cnt_q == '0);
  assign array_we    = commit & we_q;
  assign unused_addr = ^{addr_i[31:AW+BYTE_OFF_W], addr_i[BYTE_OFF_W-1:0]};

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (array_we),
    .index_i (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (array_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      done_q     <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (req) begin
`ifdef DMEM_MISALIGN_TRAP_EN
            if (addr_i[BYTE_OFF_W-1:0] != '0) begin
              state_q    <= StResp;
              done_q     <= 1'b1;
              misalign_q <= 1'b1;
            end else
`endif
            begin
              // A store wins when both controls are high.
              idx_q   <= index;
              wdata_q <= wdata_i;
              we_q    <= mem_write_i;
              cnt_q   <= CW'(LATENCY - 1);
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            if (!we_q) begin
              rdata_q <= array_rdata;
            end
            done_q  <= 1'b1;
            state_q <= StResp;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Gated by reset so the pipeline is never held while the responder is cleared.
  assign stall_o = rst_n_i & (((state_q == StIdle) & req) | (state_q == StWait));
  assign done_o  = done_q;
  assign rdata_o = rdata_q;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign_o = misalign_q;
`endif

endmodule
